// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: vehicle sensor FSM states, default
// timing constants and a small saturating-increment helper.
package tl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUAL,
    ST_PRESENT,
    ST_RELEASE,
    ST_FAULT
  } vsc_state_t;

  localparam int unsigned DEBOUNCE_CYC_DEF = 4;
  localparam int unsigned MIN_HOLD_CYC_DEF = 30;
  localparam int unsigned MAX_HOLD_CYC_DEF = 200;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vehicle_sensor_conditioner_if.sv
// Loop-sensor side signals of the vehicle sensor conditioner.
interface vehicle_sensor_conditioner_if;
  import tl_pkg::*;

  logic       loop_raw;
  logic       clr_count;
  logic       sensor;
  logic       vehicle_pulse;
  logic [7:0] veh_count;
  logic       fault;

  modport master (
    output loop_raw, clr_count,
    input  sensor, vehicle_pulse, veh_count, fault
  );

  modport slave (
    input  loop_raw, clr_count,
    output sensor, vehicle_pulse, veh_count, fault
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Debounces a raw inductive-loop level into a qualified vehicle-present
// level, arrival strobe, saturating arrival count and stuck-loop fault.
module vehicle_sensor_conditioner
  import tl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned MIN_HOLD_CYC = MIN_HOLD_CYC_DEF,
  parameter int unsigned MAX_HOLD_CYC = MAX_HOLD_CYC_DEF
) (
  input logic                         clk,
  input logic                         rst,
  vehicle_sensor_conditioner_if.slave bus
);

  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_CYC - 1);
  localparam logic [3:0] DEB_FULL   = 4'(DEBOUNCE_CYC);
  localparam logic [7:0] MIN_HOLD   = 8'(MIN_HOLD_CYC);
  localparam logic [9:0] STUCK_LAST = 10'(MAX_HOLD_CYC - 1);

  logic       w_loop_s;
  vsc_state_t r_state;
  logic [3:0] r_deb_cnt;
  logic [7:0] r_on_cnt;
  logic [9:0] r_stuck_cnt;
  logic       r_sensor;
  logic       r_pulse;
  logic       r_fault;
  logic [7:0] r_veh_count;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.loop_raw),
    .o_q (w_loop_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_deb_cnt   <= '0;
      r_on_cnt    <= '0;
      r_stuck_cnt <= '0;
      r_sensor    <= 1'b0;
      r_pulse     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (r_state inside {ST_PRESENT, ST_RELEASE})
        r_on_cnt <= sat_inc8(r_on_cnt);
      case (r_state)
        ST_IDLE: begin
          if (w_loop_s) begin
            r_state   <= ST_QUAL;
            r_deb_cnt <= 4'd1;
          end
        end
        ST_QUAL: begin
          if (!w_loop_s) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= ST_PRESENT;
            r_deb_cnt   <= '0;
            r_on_cnt    <= '0;
            r_stuck_cnt <= '0;
            r_sensor    <= 1'b1;
            r_pulse     <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + 4'd1;
          end
        end
        ST_PRESENT: begin
          if (w_loop_s) begin
            if (r_stuck_cnt == STUCK_LAST) begin
              r_state     <= ST_FAULT;
              r_stuck_cnt <= '0;
              r_deb_cnt   <= '0;
              r_sensor    <= 1'b0;
              r_fault     <= 1'b1;
            end else begin
              r_stuck_cnt <= r_stuck_cnt + 10'd1;
            end
          end else begin
            r_state     <= ST_RELEASE;
            r_deb_cnt   <= 4'd1;
            r_stuck_cnt <= '0;
          end
        end
        ST_RELEASE: begin
          // deb_cnt counts lows taken before this one; exit needs this low to complete the run
          if (w_loop_s) begin
            r_state   <= ST_PRESENT;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt >= DEB_LAST && r_on_cnt >= MIN_HOLD) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_sensor  <= 1'b0;
          end else if (r_deb_cnt != DEB_FULL) begin
            r_deb_cnt <= r_deb_cnt + 4'd1;
          end
        end
        ST_FAULT: begin
          if (w_loop_s) begin
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_fault   <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A clear coinciding with an arrival keeps that arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_veh_count <= '0;
    else if (bus.clr_count)
      r_veh_count <= r_pulse ? 8'd1 : 8'd0;
    else if (r_pulse)
      r_veh_count <= sat_inc8(r_veh_count);
  end

  assign bus.sensor        = r_sensor;
  assign bus.vehicle_pulse = r_pulse;
  assign bus.veh_count     = r_veh_count;
  assign bus.fault         = r_fault;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus random loop activity against
// a cycle-level behavioural model of the sensor conditioner.
module tb_vehicle_sensor_conditioner;

  localparam int DEB      = 4;
  localparam int MIN_HOLD = 30;
  localparam int MAX_HOLD = 200;

  logic clk;
  logic rst;
  vehicle_sensor_conditioner_if bus ();

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYC (DEB),
    .MIN_HOLD_CYC (MIN_HOLD),
    .MAX_HOLD_CYC (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse_seen = 0;
  int n_sensor_hi = 0;

  // Behavioural model state
  bit    m_s1, m_s2, m_pulse;
  int    m_count, m_run, m_lows, m_time, m_stuck;
  string m_mode;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_pulse = 0;
    m_count = 0; m_run = 0; m_lows = 0; m_time = 0; m_stuck = 0;
    m_mode = "idle";
  endtask

  task automatic model_edge(input bit raw, input bit clr);
    bit ls;
    bit was_pulse;
    bit held_long;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    was_pulse = m_pulse;
    m_pulse = 0;
    held_long = (m_time >= MIN_HOLD);
    if (m_mode == "present" || m_mode == "release")
      m_time = (m_time < 255) ? m_time + 1 : 255;
    if (m_mode == "idle") begin
      if (ls) begin m_mode = "qual"; m_run = 1; end
    end else if (m_mode == "qual") begin
      if (!ls) m_mode = "idle";
      else begin
        m_run++;
        if (m_run == DEB) begin
          m_mode = "present"; m_time = 0; m_stuck = 0; m_pulse = 1;
        end
      end
    end else if (m_mode == "present") begin
      if (ls) begin
        m_stuck++;
        if (m_stuck == MAX_HOLD) begin m_mode = "fault"; m_lows = 0; end
      end else begin
        m_mode = "release"; m_lows = 1; m_stuck = 0;
      end
    end else if (m_mode == "release") begin
      if (ls) m_mode = "present";
      else begin
        if (m_lows < DEB) m_lows++;
        if (m_lows == DEB && held_long) m_mode = "idle";
      end
    end else begin
      if (ls) m_lows = 0;
      else begin
        m_lows++;
        if (m_lows == DEB) m_mode = "idle";
      end
    end
    if (clr) m_count = was_pulse ? 1 : 0;
    else if (was_pulse && m_count < 255) m_count++;
  endtask

  task automatic tick(input bit raw, input bit clr);
    bit exp_sensor;
    bus.loop_raw = raw;
    bus.clr_count = clr;
    @(posedge clk);
    #1;
    model_edge(raw, clr);
    exp_sensor = (m_mode == "present" || m_mode == "release");
    check("sensor", {7'd0, bus.sensor}, {7'd0, exp_sensor});
    check("vehicle_pulse", {7'd0, bus.vehicle_pulse}, {7'd0, m_pulse});
    check("veh_count", bus.veh_count, 8'(m_count));
    check("fault", {7'd0, bus.fault}, {7'd0, (m_mode == "fault")});
    if (bus.vehicle_pulse === 1'b1) n_pulse_seen++;
    if (bus.sensor === 1'b1) n_sensor_hi++;
  endtask

  task automatic settle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(m_mode == "idle" && bus.sensor === 1'b0 && bus.fault === 1'b0) && n < budget) begin
      tick(0, 0);
      n++;
    end
    check(tag, {7'd0, (n >= budget)}, 8'd0);
  endtask

  initial begin
    int p0, h0, drops, guard;
    bit risen, fault_seen;
    rst = 1'b1;
    bus.loop_raw = 1'b0;
    bus.clr_count = 1'b0;
    model_reset();
    #1;
    check("reset_sensor", {7'd0, bus.sensor}, 8'd0);
    check("reset_pulse", {7'd0, bus.vehicle_pulse}, 8'd0);
    check("reset_count", bus.veh_count, 8'd0);
    check("reset_fault", {7'd0, bus.fault}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Steady high from edge 0: sensor at edge 6, pulse edge 6 only, count at edge 7
    for (int e = 1; e <= 7; e++) begin
      tick(1, 0);
      if (e == 5) check("rise_e5_sensor", {7'd0, bus.sensor}, 8'd0);
      if (e == 6) begin
        check("rise_e6_sensor", {7'd0, bus.sensor}, 8'd1);
        check("rise_e6_pulse", {7'd0, bus.vehicle_pulse}, 8'd1);
      end
      if (e == 7) begin
        check("rise_e7_pulse", {7'd0, bus.vehicle_pulse}, 8'd0);
        check("rise_e7_count", bus.veh_count, 8'd1);
      end
    end
    settle("settle_first", 300);

    // Short glitches are rejected
    p0 = n_pulse_seen; h0 = n_sensor_hi;
    repeat (3) tick(1, 0);
    repeat (5) tick(0, 0);
    repeat (2) tick(1, 0);
    repeat (10) tick(0, 0);
    check("glitch_pulses", 8'(n_pulse_seen - p0), 8'd0);
    check("glitch_sensor", 8'(n_sensor_hi - h0), 8'd0);
    check("glitch_count", bus.veh_count, 8'd1);

    // 10-cycle presence is stretched to the minimum hold
    p0 = n_pulse_seen; h0 = n_sensor_hi;
    repeat (10) tick(1, 0);
    settle("settle_short", 300);
    check("short_pulses", 8'(n_pulse_seen - p0), 8'd1);
    check("short_hold_cycles", 8'(n_sensor_hi - h0), 8'd31);

    // Brief dropout inside a long presence is bridged
    p0 = n_pulse_seen; risen = 0; drops = 0;
    for (int k = 0; k < 82; k++) begin
      tick((k < 40 || k >= 42), 0);
      if (bus.sensor === 1'b1) risen = 1;
      else if (risen) drops++;
    end
    check("bridge_drops", 8'(drops), 8'd0);
    settle("settle_bridge", 300);
    check("bridge_pulses", 8'(n_pulse_seen - p0), 8'd1);

    // Stuck loop raises fault, then clears after DEB low samples
    fault_seen = 0;
    repeat (300) begin
      tick(1, 0);
      if (bus.fault === 1'b1) fault_seen = 1;
    end
    check("stuck_fault_seen", {7'd0, fault_seen}, 8'd1);
    check("stuck_sensor", {7'd0, bus.sensor}, 8'd0);
    check("stuck_fault", {7'd0, bus.fault}, 8'd1);
    repeat (5) tick(0, 0);
    check("fault_hold_e5", {7'd0, bus.fault}, 8'd1);
    tick(0, 0);
    check("fault_clear_e6", {7'd0, bus.fault}, 8'd0);

    // Count saturation
    for (int a = 0; a < 260; a++) begin
      repeat (5) tick(1, 0);
      settle("settle_arrival", 300);
    end
    check("count_saturated", bus.veh_count, 8'd255);

    // Clear coinciding with an increment
    guard = 0;
    while (!m_pulse && guard < 20) begin
      tick(1, 0);
      guard++;
    end
    check("clr_pulse_timeout", {7'd0, (guard >= 20)}, 8'd0);
    tick(1, 1);
    check("clr_with_inc", bus.veh_count, 8'd1);
    settle("settle_clr", 300);

    // Plain clear
    tick(0, 1);
    check("clr_plain", bus.veh_count, 8'd0);

    // Asynchronous reset while PRESENT
    guard = 0;
    while (m_mode != "present" && guard < 20) begin
      tick(1, 0);
      guard++;
    end
    check("reach_present", {7'd0, (guard >= 20)}, 8'd0);
    tick(1, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_sensor", {7'd0, bus.sensor}, 8'd0);
    check("async_rst_count", bus.veh_count, 8'd0);
    check("async_rst_pulse", {7'd0, bus.vehicle_pulse}, 8'd0);
    check("async_rst_fault", {7'd0, bus.fault}, 8'd0);
    model_reset();
    bus.loop_raw = 1'b0;
    #2;
    rst = 1'b0;
    p0 = n_pulse_seen;
    repeat (10) tick(0, 0);
    check("post_rst_pulses", 8'(n_pulse_seen - p0), 8'd0);

    // Random loop activity
    for (int r = 0; r < 80; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) tick(lvl, ($urandom_range(0, 15) == 0));
    end
    settle("settle_random", 400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
